// File: rtl/ecc_key_pkg.sv
// ---------------------------------------------------------------------------
// ecc_key_pkg
//   Shared definitions for the ECC scalar-digit scanner:
//     - FSM state encoding (IDLE / SKIP / EMIT)
//     - default scalar width (B-233 order width)
//     - constant helper functions used to size the digit count and the
//       remaining-digit counter
// ---------------------------------------------------------------------------
package ecc_key_pkg;

    // FSM state encoding, kept as plain constants so older tools and
    // waveform viewers see a fixed 2-bit code.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SKIP = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;

    // Default scalar width: the B-233 group order.
    localparam int DEFAULT_KEY_W = 233;

    // Integer ceiling division, usable in parameter expressions.
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ecc_key_scanner.sv
// ---------------------------------------------------------------------------
// ecc_key_scanner
//   Loads a KEY_W-bit scalar and hands it out MSB-first as WIN_W-bit digits,
//   one digit per STEP handshake, to the double/add sequencer. Optionally
//   consumes leading all-zero digits internally so the sequencer never sees
//   them.
//
// Parameters
//   KEY_W    scalar width in bits
//   WIN_W    digit width in bits (1..4)
//   SKIP_LZ  1 = leading zero digits are skipped internally
//
// Ports
//   CLK          sole clock, rising edge
//   RST          asynchronous active-high reset
//   DIN          scalar to load
//   IN_VALID     load request (accepted only while IN_READY)
//   IN_READY     high only in IDLE
//   STEP         consumer accepts the current digit
//   ABORT        discard the current scalar (ignored in IDLE)
//   DIGIT        current digit, MSB-first (0 when not valid)
//   DIGIT_VALID  DIGIT is meaningful
//   DIGIT_LAST   the current digit is the final one
//   KEY_ZERO     one-cycle pulse when a zero scalar is offered
//   BUSY         not in IDLE
//
// Every output is a register or a decode of registered state; no input
// reaches an output combinationally.
// ---------------------------------------------------------------------------
module ecc_key_scanner
    import ecc_key_pkg::*;
#(
    parameter int KEY_W   = DEFAULT_KEY_W,
    parameter int WIN_W   = 1,
    parameter int SKIP_LZ = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [KEY_W-1:0] DIN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             STEP,
    input  logic             ABORT,
    output logic [WIN_W-1:0] DIGIT,
    output logic             DIGIT_VALID,
    output logic             DIGIT_LAST,
    output logic             KEY_ZERO,
    output logic             BUSY
);

    // Geometry: the scalar is zero-extended on the MSB side so that only the
    // first digit can be partial.
    localparam int NDIG  = ceil_div(KEY_W, WIN_W);
    localparam int SR_W  = NDIG * WIN_W;
    localparam int CNT_W = clog2(NDIG + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NDIG);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_q,  state_d;
    logic [SR_W-1:0]  shreg_q,  shreg_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             kzero_q,  kzero_d;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic [SR_W-1:0]  din_ext;
    logic [SR_W-1:0]  shreg_shifted;
    logic [WIN_W-1:0] top_digit;
    logic [WIN_W-1:0] next_digit;
    logic [WIN_W-1:0] din_top_digit;
    logic             din_is_zero;

    assign din_ext       = SR_W'(DIN);
    assign shreg_shifted = shreg_q << WIN_W;
    assign top_digit     = shreg_q[SR_W-1 -: WIN_W];
    // Digit that becomes the top after this cycle's shift. The SKIP exit is
    // decided on it, so each leading zero digit costs exactly one cycle.
    assign next_digit    = shreg_shifted[SR_W-1 -: WIN_W];
    assign din_top_digit = din_ext[SR_W-1 -: WIN_W];
    assign din_is_zero   = (DIN == '0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default at the top of the block,
    // so no path through the case statement can leave it unassigned and infer
    // a latch.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        count_d = count_q;
        kzero_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // ABORT is meaningless here, so a simultaneous load wins.
                if (IN_VALID) begin
                    if (din_is_zero) begin
                        kzero_d = 1'b1;
                    end else begin
                        shreg_d = din_ext;
                        count_d = CNT_FULL;
                        // Go straight to EMIT when there is nothing to skip,
                        // giving a one-cycle load latency.
                        if ((SKIP_LZ != 0) && (din_top_digit == '0)) begin
                            state_d = ST_SKIP;
                        end else begin
                            state_d = ST_EMIT;
                        end
                    end
                end
            end

            ST_SKIP: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else begin
                    // The scalar is non-zero, so a non-zero digit is always
                    // reached before the counter runs out.
                    shreg_d = shreg_shifted;
                    count_d = count_q - CNT_ONE;
                    if (next_digit != '0) begin
                        state_d = ST_EMIT;
                    end
                end
            end

            ST_EMIT: begin
                // ABORT outranks STEP: the pending digit is not consumed.
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else if (STEP) begin
                    if (count_q == CNT_ONE) begin
                        state_d = ST_IDLE;
                    end else begin
                        shreg_d = shreg_shifted;
                        count_d = count_q - CNT_ONE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            count_q <= '0;
            kzero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
            kzero_q <= kzero_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // ------------------------------------------------------------------
    assign IN_READY    = (state_q == ST_IDLE);
    assign BUSY        = (state_q != ST_IDLE);
    assign DIGIT_VALID = (state_q == ST_EMIT);
    // DIGIT is forced to zero outside EMIT so stale shift-register contents
    // never show on the bus.
    assign DIGIT       = DIGIT_VALID ? top_digit : '0;
    assign DIGIT_LAST  = DIGIT_VALID && (count_q == CNT_ONE);
    assign KEY_ZERO    = kzero_q;

endmodule

// File: tb/tb_ecc_key_scanner.sv
// ---------------------------------------------------------------------------
// tb_ecc_key_scanner
//   Three scanner instances with different geometries share one clock:
//     i0: KEY_W=8,   WIN_W=1, SKIP_LZ=1
//     i1: KEY_W=5,   WIN_W=2, SKIP_LZ=0
//     i2: KEY_W=233, WIN_W=4, SKIP_LZ=1
//   A digit-list model predicts every output of every instance each cycle;
//   directed sequences add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_ecc_key_scanner;

    localparam int KW [3] = '{8, 5, 233};
    localparam int WW [3] = '{1, 2, 4};
    localparam int SL [3] = '{1, 0, 1};

    logic CLK;
    logic RST;

    // instance 0
    logic [7:0]   din8;
    logic         iv8, st8, ab8;
    logic [0:0]   dig8;
    logic         rdy8, dv8, last8, kz8, busy8;
    // instance 1
    logic [4:0]   din5;
    logic         iv5, st5, ab5;
    logic [1:0]   dig5;
    logic         rdy5, dv5, last5, kz5, busy5;
    // instance 2
    logic [232:0] din233;
    logic         iv233, st233, ab233;
    logic [3:0]   dig233;
    logic         rdy233, dv233, last233, kz233, busy233;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    ecc_key_scanner #(.KEY_W(8), .WIN_W(1), .SKIP_LZ(1)) u_i0 (
        .CLK(CLK), .RST(RST), .DIN(din8), .IN_VALID(iv8), .IN_READY(rdy8),
        .STEP(st8), .ABORT(ab8), .DIGIT(dig8), .DIGIT_VALID(dv8),
        .DIGIT_LAST(last8), .KEY_ZERO(kz8), .BUSY(busy8)
    );

    ecc_key_scanner #(.KEY_W(5), .WIN_W(2), .SKIP_LZ(0)) u_i1 (
        .CLK(CLK), .RST(RST), .DIN(din5), .IN_VALID(iv5), .IN_READY(rdy5),
        .STEP(st5), .ABORT(ab5), .DIGIT(dig5), .DIGIT_VALID(dv5),
        .DIGIT_LAST(last5), .KEY_ZERO(kz5), .BUSY(busy5)
    );

    ecc_key_scanner #(.KEY_W(233), .WIN_W(4), .SKIP_LZ(1)) u_i2 (
        .CLK(CLK), .RST(RST), .DIN(din233), .IN_VALID(iv233), .IN_READY(rdy233),
        .STEP(st233), .ABORT(ab233), .DIGIT(dig233), .DIGIT_VALID(dv233),
        .DIGIT_LAST(last233), .KEY_ZERO(kz233), .BUSY(busy233)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: a loaded scalar becomes a list of digits; a number of idle
    // skip cycles precedes the first emitted one; STEP pops the list.
    // ------------------------------------------------------------------
    int md    [3][64];
    int mpos  [3];
    int mend  [3];
    int mskip [3];
    bit mact  [3];
    bit mkz   [3];

    task automatic model_load(input int k, input logic [255:0] key);
        int ndig;
        int lead;
        logic [255:0] mask;
        ndig = (KW[k] + WW[k] - 1) / WW[k];
        mask = 256'((1 << WW[k]) - 1);
        for (int i = 0; i < ndig; i++) begin
            md[k][i] = int'((key >> ((ndig - 1 - i) * WW[k])) & mask);
        end
        lead = 0;
        if (SL[k] != 0) begin
            while (lead < ndig && md[k][lead] == 0) lead++;
        end
        mpos[k]  = lead;
        mskip[k] = lead;
        mend[k]  = ndig;
        mact[k]  = 1'b1;
    endtask

    task automatic model_cycle(input int k);
        bit iv, st, ab;
        logic [255:0] key;
        case (k)
            0:       begin iv = iv8;   st = st8;   ab = ab8;   key = 256'(din8);   end
            1:       begin iv = iv5;   st = st5;   ab = ab5;   key = 256'(din5);   end
            default: begin iv = iv233; st = st233; ab = ab233; key = 256'(din233); end
        endcase
        mkz[k] = 1'b0;
        if (!mact[k]) begin
            if (iv) begin
                if (key == '0) mkz[k] = 1'b1;
                else           model_load(k, key);
            end
        end else if (ab) begin
            mact[k] = 1'b0;
        end else if (mskip[k] > 0) begin
            mskip[k]--;
        end else if (st) begin
            if (mpos[k] == mend[k] - 1) mact[k] = 1'b0;
            else                        mpos[k]++;
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            mact[k] = 1'b0; mkz[k] = 1'b0; mskip[k] = 0; mpos[k] = 0; mend[k] = 0;
        end
        forever begin
            @(posedge CLK or posedge RST);
            for (int k = 0; k < 3; k++) begin
                if (RST) begin
                    mact[k] = 1'b0; mkz[k] = 1'b0; mskip[k] = 0; mpos[k] = 0;
                end else begin
                    model_cycle(k);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare process: every instance, every output, every falling edge.
    // ------------------------------------------------------------------
    always @(negedge CLK) begin : cmp
        int a_dig, a_dv, a_last, a_kz, a_busy, a_rdy;
        int e_dig, e_dv, e_last;
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                case (k)
                    0: begin
                        a_dig = int'(dig8); a_dv = int'(dv8); a_last = int'(last8);
                        a_kz = int'(kz8); a_busy = int'(busy8); a_rdy = int'(rdy8);
                    end
                    1: begin
                        a_dig = int'(dig5); a_dv = int'(dv5); a_last = int'(last5);
                        a_kz = int'(kz5); a_busy = int'(busy5); a_rdy = int'(rdy5);
                    end
                    default: begin
                        a_dig = int'(dig233); a_dv = int'(dv233); a_last = int'(last233);
                        a_kz = int'(kz233); a_busy = int'(busy233); a_rdy = int'(rdy233);
                    end
                endcase
                e_dv   = (mact[k] && mskip[k] == 0) ? 1 : 0;
                e_dig  = (e_dv != 0) ? md[k][mpos[k]] : 0;
                e_last = (e_dv != 0 && mend[k] - mpos[k] == 1) ? 1 : 0;
                check($sformatf("i%0d_digit", k),       a_dig,  e_dig);
                check($sformatf("i%0d_digit_valid", k), a_dv,   e_dv);
                check($sformatf("i%0d_digit_last", k),  a_last, e_last);
                check($sformatf("i%0d_key_zero", k),    a_kz,   mkz[k] ? 1 : 0);
                check($sformatf("i%0d_busy", k),        a_busy, mact[k] ? 1 : 0);
                check($sformatf("i%0d_in_ready", k),    a_rdy,  mact[k] ? 0 : 1);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    initial begin
        int n;
        int ones;
        logic [5:0] bits;

        RST = 1'b1;
        din8 = '0;   iv8 = 0;   st8 = 0;   ab8 = 0;
        din5 = '0;   iv5 = 0;   st5 = 0;   ab5 = 0;
        din233 = '0; iv233 = 0; st233 = 0; ab233 = 0;
        chk_en = 1'b1;
        #1;
        check("reset_in_ready", rdy8, 1);
        check("reset_digit_valid", dv8, 0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        tick();

        // 8'h2D, skip on, STEP held high: two skip cycles, then 1,0,1,1,0,1.
        din8 = 8'h2D; iv8 = 1; st8 = 1;
        tick();
        iv8 = 0;
        n = 0;
        while (!dv8 && n < 10) begin n++; tick(); end
        check("t1_skip_cycles", n, 2);
        bits = '0;
        for (int i = 0; i < 6; i++) begin
            check("t1_valid", dv8, 1);
            bits = {bits[4:0], dig8};
            check("t1_last", last8, (i == 5) ? 1 : 0);
            tick();
        end
        check("t1_digits", bits, 6'b101101);
        check("t1_ready_after", rdy8, 1);
        st8 = 0;
        tick();

        // 5'b10110, 2-bit digits, no skipping: 01,01,10 with a 3-cycle stall.
        din5 = 5'b10110; iv5 = 1;
        tick();
        iv5 = 0;
        check("t2_latency_valid", dv5, 1);
        check("t2_digit0", dig5, 2'b01);
        st5 = 1;
        tick();
        st5 = 0;
        for (int i = 0; i < 3; i++) begin
            check("t2_stall_valid", dv5, 1);
            check("t2_stall_digit", dig5, 2'b01);
            tick();
        end
        st5 = 1;
        tick();
        check("t2_digit2", dig5, 2'b10);
        check("t2_last", last5, 1);
        tick();
        st5 = 0;
        check("t2_idle", busy5, 0);

        // ABORT alone in IDLE is ignored; ABORT with a load lets the load win.
        ab5 = 1;
        tick();
        check("abort_idle_ready", rdy5, 1);
        din5 = 5'b00001; iv5 = 1;
        tick();
        iv5 = 0; ab5 = 0;
        check("load_beats_abort", dv5, 1);
        check("load_beats_abort_dig", dig5, 0);
        st5 = 1;
        tick();
        tick();
        check("t2b_final_digit", dig5, 2'b01);
        check("t2b_final_last", last5, 1);
        tick();
        st5 = 0;

        // Zero scalar: one-cycle KEY_ZERO, never busy, never valid.
        din8 = 8'h00; iv8 = 1;
        tick();
        iv8 = 0;
        check("t3_key_zero", kz8, 1);
        check("t3_busy", busy8, 0);
        check("t3_valid", dv8, 0);
        tick();
        check("t3_key_zero_drop", kz8, 0);
        check("t3_valid_after", dv8, 0);

        // 233-bit scalar of value 1 with 4-bit digits: 58 skips, one digit.
        din233 = 233'd1; iv233 = 1; st233 = 1;
        tick();
        iv233 = 0;
        n = 0;
        while (!dv233 && n < 100) begin n++; tick(); end
        check("t4_skip_cycles", n, 58);
        check("t4_digit", dig233, 4'h1);
        check("t4_last", last233, 1);
        tick();
        st233 = 0;
        check("t4_idle", busy233, 0);

        // 8'hB5: ignored load during EMIT, then ABORT with STEP on digit 3.
        din8 = 8'hB5; iv8 = 1; st8 = 1;
        tick();
        check("t5_digit1", dig8, 1);
        din8 = 8'h7F; iv8 = 1;
        tick();
        iv8 = 0;
        check("t5_digit2", dig8, 0);
        check("t5_digit2_valid", dv8, 1);
        tick();
        check("t5_digit3", dig8, 1);
        ab8 = 1;
        tick();
        ab8 = 0; st8 = 0;
        check("t5_abort_valid", dv8, 0);
        check("t5_abort_ready", rdy8, 1);
        tick();

        // Asynchronous reset mid-EMIT, then a fresh 8'hFF load.
        din8 = 8'hA5; iv8 = 1;
        tick();
        iv8 = 0;
        tick();
        check("t6_pre_reset_valid", dv8, 1);
        #1 RST = 1'b1;
        #1;
        check("t6_rst_digit", dig8, 0);
        check("t6_rst_valid", dv8, 0);
        check("t6_rst_last", last8, 0);
        check("t6_rst_key_zero", kz8, 0);
        check("t6_rst_busy", busy8, 0);
        check("t6_rst_ready", rdy8, 1);
        @(posedge CLK);
        #1 RST = 1'b0;
        tick();
        din8 = 8'hFF; iv8 = 1; st8 = 1;
        tick();
        iv8 = 0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            if (dv8 && dig8 == 1'b1) ones++;
            tick();
        end
        st8 = 0;
        check("t6_ones", ones, 8);
        check("t6_idle", busy8, 0);

        repeat (3) tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
